// File: rtl/div_if.sv
// Request/response bundle between the EX decoder and the integer divider.
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  start;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  stall_req;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, stall_req
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Result is {remainder, quotient}; stall_req holds the pipeline while busy.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quot_q, quot_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic                  quot_neg_q, quot_neg_d;
  logic                  rem_neg_q, rem_neg_d;

  logic [DATA_W:0]       rem_sh;
  logic                  step_ge;
  logic [DATA_W-1:0]     rem_step;
  logic [DATA_W-1:0]     quot_step;

  // Magnitude of an operand; only negative values under DIV are negated.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic sd);
    if (sd && v[DATA_W-1]) return -v;
    return v;
  endfunction

  // Two's-complement negate when the result sign must be flipped.
  function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    if (neg) return -v;
    return v;
  endfunction

  // One restoring step: the partial remainder needs DATA_W+1 bits since it
  // can reach 2*divisor-1 before the trial subtraction.
  assign rem_sh    = {rem_q, quot_q[DATA_W-1]};
  assign step_ge   = (rem_sh >= {1'b0, dvs_q});
  assign rem_step  = step_ge ? (rem_sh[DATA_W-1:0] - dvs_q) : rem_sh[DATA_W-1:0];
  assign quot_step = {quot_q[DATA_W-2:0], step_ge};

  assign bus.result    = result_q;
  assign bus.ready     = ready_q;
  assign bus.stall_req = bus.start & ~ready_q;

  // Next-state, iteration and output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    ready_d    = ready_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_d = BYZERO;
          end else begin
            state_d    = ON;
            cnt_d      = '0;
            rem_d      = '0;
            quot_d     = mag(bus.opdata1, bus.signed_div);
            dvs_d      = mag(bus.opdata2, bus.signed_div);
            quot_neg_d = bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
            rem_neg_d  = bus.signed_div & bus.opdata1[DATA_W-1];
          end
        end
      end
      BYZERO: begin
        result_d = '0;
        if (bus.annul) begin
          state_d = FREE;
          ready_d = 1'b0;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (bus.annul) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {sign_fix(rem_step, rem_neg_q), sign_fix(quot_step, quot_neg_q)};
          end
        end
      end
      END: begin
        if (!bus.start) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Datapath registers; only meaningful while ON, so no reset.
  always_ff @(posedge clk) begin
    rem_q      <= rem_d;
    quot_q     <= quot_d;
    dvs_q      <= dvs_d;
    quot_neg_q <= quot_neg_d;
    rem_neg_q  <= rem_neg_d;
  end
endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed scenarios plus randomized operations
// compared against an arithmetic reference model.
module tb_div_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_if #(.DATA_W(32)) bus();

  div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division, remainder takes dividend sign, x/0 -> 0.
  function automatic logic [63:0] model(input bit sd, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    if (b == 32'h0) return 64'h0;
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      ua = {32'h0, a};
      ub = {32'h0, b};
      uq = ua / ub;
      ur = ua % ub;
      res = {ur[31:0], uq[31:0]};
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a division and waits for ready (bounded). Returns the result, the
  // number of cycles from C0 to ready, stall cycles and stall_req at ready.
  task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [63:0] res,
                         output int lat, output int stalls, output logic stall_end);
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.annul      = 1'b0;
    bus.start      = 1'b1;
    lat    = 0;
    stalls = 0;
    stall_end = 1'b1;
    res = 'x;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        stall_end = bus.stall_req;
        res = bus.result;
        break;
      end
      if (bus.stall_req === 1'b1) stalls++;
      @(posedge clk);
      #1;
      lat++;
      if (scramble) begin
        bus.opdata1 = $urandom;
        bus.opdata2 = $urandom;
        bus.signed_div = $urandom_range(0, 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    total++;
    if (bus.ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", bus.ready);
    end
    total++;
    if (bus.result !== 64'h0) begin
      bad++; $display("FAIL reset_result: got %h want 0", bus.result);
    end
    total++;
    if (bus.stall_req !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_req);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] res; int lat, stalls; logic se;
    run_div(1'b0, 32'd100, 32'd7, 1'b1, res, lat, stalls, se);
    total++;
    if (lat !== 33) begin
      bad++; $display("FAIL unsigned_latency: got %0d want 33", lat);
    end
    total++;
    if (res !== {32'd2, 32'd14}) begin
      bad++; $display("FAIL unsigned_result: got %h want %h", res, {32'd2, 32'd14});
    end
    total++;
    if (stalls !== 33 || se !== 1'b0) begin
      bad++; $display("FAIL unsigned_stall: got %0d/%b want 33/0", stalls, se);
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_signed();
    logic [63:0] res; int lat, stalls; logic se;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, res, lat, stalls, se);
    total++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      bad++; $display("FAIL signed_neg_dividend: got %h want ffffffff_fffffffd", res);
    end
    bus.start = 1'b0;
    tick();
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, res, lat, stalls, se);
    total++;
    if (res !== {32'd1, 32'hFFFFFFFD}) begin
      bad++; $display("FAIL signed_neg_divisor: got %h want 00000001_fffffffd", res);
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_div_zero();
    logic [63:0] res; int lat, stalls; logic se;
    run_div(1'b0, 32'd123, 32'd0, 1'b0, res, lat, stalls, se);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL divzero_latency: got %0d want 2", lat);
    end
    total++;
    if (res !== 64'h0) begin
      bad++; $display("FAIL divzero_result: got %h want 0", res);
    end
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.ready !== 1'b0) begin
      bad++; $display("FAIL divzero_release: ready got %b want 0", bus.ready);
    end
  endtask

  task automatic test_annul();
    logic [63:0] res; int lat, stalls; logic se;
    int seen;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd5000;
    bus.opdata2 = 32'd3;
    bus.annul = 1'b0;
    bus.start = 1'b1;
    repeat (10) tick();
    bus.annul = 1'b1;
    tick();
    bus.annul = 1'b0;
    bus.start = 1'b0;
    total++;
    if (bus.ready !== 1'b0 || bus.result !== 64'h0) begin
      bad++; $display("FAIL annul_outputs: ready %b result %h want 0/0", bus.ready, bus.result);
    end
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.ready === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL annul_no_ready: ready cycles %0d want 0", seen);
    end
    run_div(1'b0, 32'd5000, 32'd3, 1'b0, res, lat, stalls, se);
    total++;
    if (lat !== 33 || res !== model(1'b0, 32'd5000, 32'd3)) begin
      bad++; $display("FAIL annul_restart: lat %0d result %h want 33/%h", lat, res,
                      model(1'b0, 32'd5000, 32'd3));
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_overflow_hold();
    logic [63:0] res; int lat, stalls; logic se;
    int unstable;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, res, lat, stalls, se);
    total++;
    if (res !== {32'h0, 32'h80000000}) begin
      bad++; $display("FAIL overflow_result: got %h want 00000000_80000000", res);
    end
    unstable = 0;
    repeat (3) begin
      tick();
      if (bus.ready !== 1'b1 || bus.result !== {32'h0, 32'h80000000}) unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL overflow_hold: unstable cycles %0d want 0", unstable);
    end
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.ready !== 1'b0 || bus.result !== 64'h0) begin
      bad++; $display("FAIL overflow_release: ready %b result %h want 0/0", bus.ready, bus.result);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int lat, stalls; logic se;
    bus.signed_div = 1'b1;
    bus.opdata1 = 32'hFFFF0000;
    bus.opdata2 = 32'd9;
    bus.annul = 1'b0;
    bus.start = 1'b1;
    repeat (15) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (bus.ready !== 1'b0 || bus.result !== 64'h0) begin
      bad++; $display("FAIL reset_mid_outputs: ready %b result %h want 0/0", bus.ready, bus.result);
    end
    run_div(1'b1, 32'hFFFF0000, 32'd9, 1'b0, res, lat, stalls, se);
    total++;
    if (lat !== 33 || res !== model(1'b1, 32'hFFFF0000, 32'd9)) begin
      bad++; $display("FAIL reset_mid_restart: lat %0d result %h want 33/%h", lat, res,
                      model(1'b1, 32'hFFFF0000, 32'd9));
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [63:0] res, exp; int lat, stalls; logic se;
    logic [31:0] a, b; bit sd;
    for (int i = 0; i < 30; i++) begin
      sd = bit'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h80000000;
        3: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (i % 7 == 0) a = 32'h80000000;
      exp = model(sd, a, b);
      run_div(sd, a, b, 1'b1, res, lat, stalls, se);
      total++;
      if (res !== exp || lat !== ((b == 0) ? 2 : 33)) begin
        bad++;
        $display("FAIL random_%0d: sd=%0d a=%h b=%h got %h lat %0d want %h", i, sd, a, b,
                 res, lat, exp);
      end
      bus.start = 1'b0;
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_overflow_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage; executes DIV and DIVU.
- Produces the EX stall request that feeds the pipeline stall controller, which holds IF/ID/EX while a division is in flight.
- Result {remainder, quotient} goes to the HI/LO write path of EX/MEM.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  input  32  dividend.
- opdata2  input  32  divisor.
- start  input  1  division request from the EX decoder; held high until ready is seen.
- annul  input  1  cancels the operation in flight (pipeline flush).
- result  output  64  {remainder[63:32], quotient[31:0]}; registered.
- ready  output  1  result valid; registered.
- stall_req  output  1  EX stall request to the stall controller; combinational, equals start & ~ready.

Behaviour:
- States: FREE, BYZERO, ON, END. The FSM, counter and outputs are all registered.
- Reset: rst==0 at a rising edge forces state=FREE, cnt=0, result=0, ready=0. Reset takes priority over everything, including an operation in progress.
- FREE state:
  - start=1 & annul=0 & opdata2==0 -> BYZERO.
  - start=1 & annul=0 & opdata2!=0 -> ON. On this edge, latch signed_div, latch the operand magnitudes (negate any negative operand when signed_div=1), and set cnt=0.
  - Otherwise stay in FREE.
  - ready=0 and result=0 throughout.
- BYZERO state: next edge -> END with result=64'h0.
- ON state:
  - annul=1 -> FREE, with ready=0 and result=0. Annul takes priority over the iteration step.
  - Otherwise perform one restoring step per cycle: shift {rem, quot} left by 1; trial-subtract the divisor magnitude; if there is no borrow, keep the difference and set the quotient LSB to 1.
  - cnt increments each step. On the step with cnt==DATA_W-1, go to END.
- Sign fix on entering END (signed only):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder is negated if the dividend is negative, so the remainder sign follows the dividend.
  - result and ready=1 are registered on the same edge.
- END state:
  - Holds result, ready=1.
  - start=0 -> FREE, ready=0, result=0.
  - start=1 -> stay in END, so no re-issue happens while EX is still stalled.
  - annul is ignored in END.
- Latency: start first high in cycle C0 (FREE).
  - C1..C32 are in ON.
  - ready=1 in C33.
  - stall_req is high in C0..C32 (33 cycles) and low in C33, so the pipeline advances at the end of C33.
  - For divide-by-zero, ready=1 in C2.
- Overflow: signed -2^31 / -1 gives quotient 32'h80000000 and remainder 0, with no exception.
- Operands are sampled only on the FREE->ON edge; later changes on opdata1/opdata2 have no effect.
- annul in FREE or BYZERO:
  - FREE: no transition.
  - BYZERO: -> FREE.

Test Plan:
- Unsigned: opdata1=100, opdata2=7, signed_div=0, start held until ready -> ready=1 exactly in C33, result={32'd2, 32'd14}, stall_req high for 33 cycles.
- Signed: opdata1=-7 (32'hFFFFFFF9), opdata2=2, signed_div=1 -> quotient 32'hFFFFFFFD (-3), remainder 32'hFFFFFFFF (-1). Also cover 7/-2 -> q=-3, r=1.
- Divide by zero: opdata2=0, opdata1=123 -> ready=1 in C2, result=64'h0. Drop start -> FREE next edge, ready=0.
- Annul: start a division, assert annul in C10 -> state FREE at the next edge, ready never asserts. A new start then completes normally with the correct result.
- Overflow and hold: signed 32'h80000000 / 32'hFFFFFFFF -> result={32'h0, 32'h80000000}. Keep start high 3 extra cycles -> ready and result stay stable with no re-issue. Drop start -> ready=0, result=0.
- Reset mid-operation: rst=0 in C15 for one cycle -> ready=0, result=0, state FREE after that edge. With start still high after reset, the division restarts from the beginning and ready=1 arrives 33 cycles later.
